// File: rtl/uart_transmitter.sv
// uart_transmitter
//   8-bit asynchronous serial transmitter with a selectable baud rate.
//   Frame: start bit (0), 8 data bits LSB first, optional even-parity bit,
//   stop bit (1). Every bit lasts 16 sample ticks; one tick is produced
//   every N clk cycles, where N comes from the rate code latched with the byte.
//
//   Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
//   (XOR of the 8 data bits) between the last data bit and the stop bit,
//   giving an 11-bit frame. Without it the frame is 10 bits.
//
// Ports
//   clk          system clock (50 MHz), rising edge
//   reset        synchronous, active-high
//   Tx_DATA[7:0] byte to send, latched on acceptance
//   Tx_WR        one-cycle write strobe
//   Tx_EN        transmitter enable; dropping it aborts a frame in progress
//   baud_select  rate code, latched on acceptance
//   TxD          serial line, idles high
//   Tx_BUSY      high while a frame is in progress
module uart_transmitter (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic       Tx_WR,
  input  logic       Tx_EN,
  input  logic [2:0] baud_select,
  output logic       TxD,
  output logic       Tx_BUSY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [13:0] div_cnt_reg, div_cnt_next;
  logic [3:0]  tick_cnt_reg, tick_cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  data_reg, data_next;
  logic [2:0]  baud_reg, baud_next;
  logic        txd_reg, txd_next;

  logic [13:0] div_value;
  logic        tick;
  logic        bit_done;

  // Divider for the 16x tick, taken from the rate latched with the current
  // byte so a live change of baud_select cannot disturb a frame.
  always_comb begin
    case (baud_reg)
      3'b000:  div_value = 14'd10417;
      3'b001:  div_value = 14'd2604;
      3'b010:  div_value = 14'd651;
      3'b011:  div_value = 14'd326;
      3'b100:  div_value = 14'd163;
      3'b101:  div_value = 14'd81;
      3'b110:  div_value = 14'd54;
      default: div_value = 14'd27;
    endcase
  end

  assign tick     = (div_cnt_reg == div_value - 14'd1);
  assign bit_done = tick && (tick_cnt_reg == 4'd15);

`ifdef UART_TX_PARITY_EN
  // Even parity as an explicit XOR chain over the latched byte.
  genvar gi;
  logic [8:0] par_chain;
  logic       parity_bit;
  assign par_chain[0] = 1'b0;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ data_reg[gi];
    end
  endgenerate
  assign parity_bit = par_chain[8];
`endif

  always_comb begin
    state_next    = state_reg;
    div_cnt_next  = div_cnt_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    data_next     = data_reg;
    baud_next     = baud_reg;
    txd_next      = 1'b1;

    if (state_reg == IDLE) begin
      // Counters held at zero so the start bit always gets its full length.
      div_cnt_next  = 14'd0;
      tick_cnt_next = 4'd0;
      bit_idx_next  = 3'd0;
      if (Tx_WR && Tx_EN) begin
        state_next = START;
        data_next  = Tx_DATA;
        baud_next  = baud_select;
      end
    end else if (!Tx_EN) begin
      // Abort: straight back to idle with everything cleared.
      state_next    = IDLE;
      div_cnt_next  = 14'd0;
      tick_cnt_next = 4'd0;
      bit_idx_next  = 3'd0;
    end else begin
      if (tick) begin
        div_cnt_next  = 14'd0;
        tick_cnt_next = tick_cnt_reg + 4'd1;
      end else begin
        div_cnt_next  = div_cnt_reg + 14'd1;
      end

      if (bit_done) begin
        case (state_reg)
          START: begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
          end
          DATA: begin
            // Index only wraps by leaving DATA, so bit 0 is never resent.
            if (bit_idx_reg == 3'd7) begin
              bit_idx_next = 3'd0;
`ifdef UART_TX_PARITY_EN
              state_next   = PARITY;
`else
              state_next   = STOP;
`endif
            end else begin
              bit_idx_next = bit_idx_reg + 3'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: state_next = STOP;
`endif
          STOP:    state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end
    end

    // Line level is decoded from the next state and registered, so TxD
    // comes straight from a flop and cannot glitch.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = data_next[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_next = parity_bit;
`endif
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= 14'd0;
      tick_cnt_reg <= 4'd0;
      bit_idx_reg  <= 3'd0;
      data_reg     <= 8'd0;
      baud_reg     <= 3'd0;
      txd_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      data_reg     <= data_next;
      baud_reg     <= baud_next;
      txd_reg      <= txd_next;
    end
  end

  assign TxD     = txd_reg;
  assign Tx_BUSY = (state_reg != IDLE);

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL use the port `clk`, input, 1 bit, as its single system clock (50 MHz); all logic SHALL be on the rising edge.
REQ-002 The block SHALL use the port `reset`, input, 1 bit: reset is synchronous and active-high.
REQ-003 The block SHALL have the port `Tx_DATA`, input, 8 bits: the byte to send.
REQ-004 The block SHALL have the port `Tx_WR`, input, 1 bit: a one-cycle write strobe.
REQ-005 The block SHALL have the port `Tx_EN`, input, 1 bit: transmitter enable.
REQ-006 The block SHALL have the port `baud_select`, input, 3 bits: rate code.
REQ-007 The block SHALL have the port `TxD`, output, 1 bit: the serial line, idle high.
REQ-008 The block SHALL have the port `Tx_BUSY`, output, 1 bit: a frame is in progress.

Function
REQ-009 The block SHALL generate a 16x sample tick from a divider selected by `baud_select`; each tick SHALL be one `clk` cycle wide.
  - 000=10417 (300 baud)
  - 001=2604 (1200)
  - 010=651 (4800)
  - 011=326 (9600)
  - 100=163 (19200)
  - 101=81 (38400)
  - 110=54 (57600)
  - 111=27 (115200)
REQ-010 Each transmitted bit SHALL last exactly 16 ticks, i.e. 16*divider `clk` cycles.
REQ-011 A write SHALL be accepted only on a cycle where `Tx_WR`=1, `Tx_EN`=1 and `Tx_BUSY`=0; on acceptance the block SHALL latch `Tx_DATA` and `baud_select`.
REQ-012 Writes while `Tx_BUSY`=1 or `Tx_EN`=0 SHALL be ignored with no side effect.
REQ-013 On the cycle after acceptance, `Tx_BUSY` SHALL be 1 and `TxD` SHALL be 0 (start bit).
  - The divider and the 16-tick bit counter SHALL restart from zero at acceptance, so the start bit has full length.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with these transitions:
  - IDLE->START on acceptance.
  - START->DATA after 16 ticks.
  - DATA SHALL send bits 0..7 LSB first, 16 ticks each.
  - DATA->PARITY (if enabled) or DATA->STOP after bit 7.
  - PARITY->STOP after 16 ticks.
  - STOP SHALL drive `TxD`=1 for 16 ticks, then go to IDLE.
REQ-015 `Tx_BUSY` SHALL fall on the same cycle the FSM enters IDLE; a new write SHALL be acceptable on that cycle.
REQ-016 The 3-bit data index SHALL wrap from 7 only by leaving DATA; it SHALL never send bit 0 twice.
REQ-017 In IDLE, `TxD` SHALL be 1.
REQ-018 A change of `baud_select` mid-frame SHALL NOT affect the current frame; it SHALL apply from the next acceptance.
REQ-019 If `Tx_EN` falls mid-frame, the frame SHALL abort: on the next cycle the FSM SHALL be in IDLE, `TxD`=1, `Tx_BUSY`=0, and the counters SHALL be cleared.
REQ-020 If `Tx_WR` coincides with `Tx_EN` falling, the write SHALL NOT be accepted.

Reset
REQ-021 While `reset`=1 at a rising `clk` edge, the block SHALL set:
  - the FSM to IDLE, with `TxD`=1 and `Tx_BUSY`=0;
  - the divider counter, tick counter and bit index to 0;
  - the data and rate latches to 0.
REQ-022 Reset SHALL override a simultaneous `Tx_WR`.
REQ-023 Reset mid-frame SHALL abort the frame within one cycle, with no glitch low on `TxD` after the reset edge.

Configuration
REQ-024 With the macro `UART_TX_PARITY_EN` defined, the PARITY state SHALL be present: the frame SHALL be 11 bits and the parity bit SHALL be even parity (the XOR of the 8 data bits).
REQ-025 Without `UART_TX_PARITY_EN`, the PARITY state and its logic SHALL be absent: the frame SHALL be 10 bits and DATA SHALL go directly to STOP.

Verification
REQ-026 Byte 0xA5 at rate code 111 with parity enabled SHALL produce the following on `TxD`, each bit 432 clk, with `Tx_BUSY` high for 4752 clk:
  - start bit 0;
  - data bits 1,0,1,0,0,1,0,1 (LSB first);
  - parity bit 0;
  - stop bit 1.
REQ-027 Byte 0x01 at rate code 111 with parity disabled SHALL produce a 10-bit frame with `Tx_BUSY` high for 4320 clk; parity enabled SHALL give parity bit 1.
REQ-028 A second `Tx_WR` pulse with 0xFF issued 1000 clk into a frame SHALL be ignored: the line SHALL carry only the first byte, and 0xFF accepted on the IDLE cycle SHALL start the next frame back-to-back.
REQ-029 `Tx_EN` dropped during data bit 3 SHALL give `TxD`=1 and `Tx_BUSY`=0 on the next clk; `Tx_WR` with `Tx_EN`=0 SHALL leave `TxD` idle.
REQ-030 `reset` asserted mid-stop-bit SHALL give `TxD`=1 and `Tx_BUSY`=0 at the next edge; a `baud_select` change from 111 to 011 mid-frame SHALL keep 432-clk bits until the frame ends, and the next frame SHALL use 5216-clk bits.
